// File: rtl/wf_pkg.sv
// -----------------------------------------------------------------------------
// wf_pkg
// Shared definitions for the button conditioner:
//   - state encoding of the per-channel debounce FSM
//   - default timing constants for the 100 MHz board clock
//   - helper that sizes the per-channel counter
// -----------------------------------------------------------------------------
package wf_pkg;

  // State encoding
  localparam logic [2:0] S_IDLE         = 3'd0;
  localparam logic [2:0] S_PRESS_WAIT   = 3'd1;
  localparam logic [2:0] S_HELD         = 3'd2;
  localparam logic [2:0] S_REPEAT       = 3'd3;
  localparam logic [2:0] S_RELEASE_WAIT = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE         = S_IDLE,
    ST_PRESS_WAIT   = S_PRESS_WAIT,
    ST_HELD         = S_HELD,
    ST_REPEAT       = S_REPEAT,
    ST_RELEASE_WAIT = S_RELEASE_WAIT
  } btn_state_e;

  // Default timing at 100 MHz: 2.5 ms debounce, 250 ms first repeat,
  // 50 ms repeat period.
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 250_000;
  localparam int unsigned DEF_REPEAT_DELAY    = 25_000_000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 5_000_000;

  // Counter width large enough to hold (largest count - 1); never below 1.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    int unsigned w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = $clog2(m);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/wf_btn_channel.sv
// -----------------------------------------------------------------------------
// wf_btn_channel
// One button channel: 2-flop synchronizer, debounce / auto-repeat FSM with a
// single shared counter, and registered pulse / level outputs.
//
// Ports:
//   i_clk      system clock
//   i_rst      asynchronous active-high reset
//   i_btn_raw  raw, bouncy, asynchronous button input
//   o_pulse    one-cycle pulse per accepted press and per repeat event
//   o_level    debounced level (1 in HELD, REPEAT, RELEASE_WAIT)
// -----------------------------------------------------------------------------
module wf_btn_channel
  import wf_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_EN       = 1,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_raw,
  output logic o_pulse,
  output logic o_level
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
  localparam bit               RPT_ON   = (REPEAT_EN != 0);

  logic [1:0]       r_sync;
  btn_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;
  logic             r_level;

  btn_state_e       w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_pulse_next;
  logic             w_level_next;
  logic             w_s;

  assign w_s = r_sync[1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync  <= 2'b00;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
      r_level <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn_raw};
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_pulse <= w_pulse_next;
      r_level <= w_level_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_pulse_next = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_s) begin
          w_state_next = ST_PRESS_WAIT;
          w_cnt_next   = '0;
        end
      end

      ST_PRESS_WAIT: begin
        if (!w_s) begin
          // Bounce before the press was confirmed: drop it silently.
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt == DB_LAST) begin
          w_state_next = ST_HELD;
          w_cnt_next   = '0;
          w_pulse_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      ST_HELD: begin
        if (!w_s) begin
          w_state_next = ST_RELEASE_WAIT;
          w_cnt_next   = '0;
        end else if (RPT_ON && (r_cnt == RD_LAST)) begin
          w_state_next = ST_REPEAT;
          w_cnt_next   = '0;
          w_pulse_next = 1'b1;
        end else if (r_cnt != CNT_SAT) begin
          // Saturate so a long hold without repeat never wraps.
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      ST_REPEAT: begin
        if (!w_s) begin
          w_state_next = ST_RELEASE_WAIT;
          w_cnt_next   = '0;
        end else if (r_cnt == RP_LAST) begin
          w_cnt_next   = '0;
          w_pulse_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      ST_RELEASE_WAIT: begin
        if (w_s) begin
          // Release bounce: still held, restart the hold timing, no pulse.
          w_state_next = ST_HELD;
          w_cnt_next   = '0;
        end else if (r_cnt == DB_LAST) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Level is registered from the next state so it rises with the press pulse.
  assign w_level_next = (w_state_next == ST_HELD) ||
                        (w_state_next == ST_REPEAT) ||
                        (w_state_next == ST_RELEASE_WAIT);

  assign o_pulse = r_pulse;
  assign o_level = r_level;

endmodule

// File: rtl/wf_btn_conditioner.sv
// -----------------------------------------------------------------------------
// wf_btn_conditioner
// Conditions NUM_BTNS raw push-buttons: each is synchronized, debounced and
// turned into single-cycle press pulses (plus optional auto-repeat pulses).
// Channels are fully independent; priority is resolved downstream.
//
// Ports:
//   i_clk        system clock
//   i_rst        asynchronous active-high reset
//   i_btn_raw    raw button inputs, one bit per channel
//   o_btn_pulse  one-cycle press / repeat pulses (bit i drives btn(i+1))
//   o_btn_level  debounced held level per channel
// -----------------------------------------------------------------------------
module wf_btn_conditioner
  import wf_pkg::*;
#(
  parameter int unsigned NUM_BTNS        = 3,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_EN       = 1,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NUM_BTNS-1:0] i_btn_raw,
  output logic [NUM_BTNS-1:0] o_btn_pulse,
  output logic [NUM_BTNS-1:0] o_btn_level
);

  generate
    for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_chan
      wf_btn_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_EN       (REPEAT_EN),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_chan (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_btn_raw (i_btn_raw[gi]),
        .o_pulse   (o_btn_pulse[gi]),
        .o_level   (o_btn_level[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_wf_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_wf_btn_conditioner
// Directed bench with hand-computed expectations. Timing convention: inputs
// change 1 ns after a rising edge; the next rising edge is edge k+j for
// iteration j; outputs are sampled 1 ns after that edge.
// With DEBOUNCE_CYCLES=4 a stable press first sampled at edge k gives a pulse
// after edge k+6 and a release first sampled at edge f drops level at f+6.
// -----------------------------------------------------------------------------
module tb_wf_btn_conditioner;

  localparam int NB = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_pulse;
  logic [NB-1:0] btn_level;

  int n_checks = 0;
  int n_pass   = 0;

  wf_btn_conditioner #(
    .NUM_BTNS        (NB),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_EN       (1),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (8)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_btn_raw   (btn_raw),
    .o_btn_pulse (btn_pulse),
    .o_btn_level (btn_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input int j,
                            input logic [NB-1:0] ep, input logic [NB-1:0] el);
    check($sformatf("%s pulse j=%0d", tag, j), btn_pulse, ep);
    check($sformatf("%s level j=%0d", tag, j), btn_level, el);
  endtask

  // Let every channel settle back to IDLE.
  task automatic drain(input string tag);
    btn_raw = '0;
    repeat (16) tick();
    check_outs({tag, " drain"}, 0, '0, '0);
  endtask

  initial begin
    logic [NB-1:0] ep;
    logic [NB-1:0] el;

    // 1: reset with all buttons high, then release.
    btn_raw = 3'b111;
    for (int j = 0; j < 3; j++) begin
      tick();
      check_outs("t1 in reset", j, 3'b000, 3'b000);
    end
    rst = 1'b0;
    for (int j = 0; j < 10; j++) begin
      tick();
      ep = (j == 6) ? 3'b111 : 3'b000;
      el = (j >= 6) ? 3'b111 : 3'b000;
      check_outs("t1 release", j, ep, el);
    end
    drain("t1");
    $display("case 1 reset/release: %0d/%0d so far", n_pass, n_checks);

    // 2: fast toggling on bit 0 is rejected.
    for (int j = 0; j < 20; j++) begin
      btn_raw = (j < 8 && (j % 2) == 0) ? 3'b001 : 3'b000;
      tick();
      check_outs("t2 bounce", j, 3'b000, 3'b000);
    end
    drain("t2");
    $display("case 2 bounce reject: %0d/%0d so far", n_pass, n_checks);

    // 3: 10-cycle press on bit 1, no repeat.
    for (int j = 0; j < 25; j++) begin
      btn_raw = (j < 10) ? 3'b010 : 3'b000;
      tick();
      ep = (j == 6) ? 3'b010 : 3'b000;
      el = (j >= 6 && j < 16) ? 3'b010 : 3'b000;
      check_outs("t3 short press", j, ep, el);
    end
    drain("t3");
    $display("case 3 short press: %0d/%0d so far", n_pass, n_checks);

    // 4: 60-cycle hold on bit 2 with auto-repeat.
    for (int j = 0; j < 76; j++) begin
      btn_raw = (j < 60) ? 3'b100 : 3'b000;
      tick();
      ep = (j == 6 || j == 26 || j == 34 || j == 42 || j == 50 || j == 58) ? 3'b100 : 3'b000;
      el = (j >= 6 && j < 66) ? 3'b100 : 3'b000;
      check_outs("t4 repeat", j, ep, el);
    end
    drain("t4");
    $display("case 4 auto-repeat: %0d/%0d so far", n_pass, n_checks);

    // 5: release glitch of 2 cycles while held on bit 0.
    for (int j = 0; j < 36; j++) begin
      btn_raw = (j < 20 && j != 10 && j != 11) ? 3'b001 : 3'b000;
      tick();
      ep = (j == 6) ? 3'b001 : 3'b000;
      el = (j >= 6 && j < 26) ? 3'b001 : 3'b000;
      check_outs("t5 held glitch", j, ep, el);
    end
    drain("t5");
    $display("case 5 held glitch: %0d/%0d so far", n_pass, n_checks);

    // 6: simultaneous press on bits 0 and 2, reset during PRESS_WAIT.
    for (int j = 0; j < 4; j++) begin
      btn_raw = 3'b101;
      tick();
      check_outs("t6 pre-reset", j, 3'b000, 3'b000);
    end
    rst = 1'b1;
    tick();
    check_outs("t6 in reset", 0, 3'b000, 3'b000);
    rst = 1'b0;
    for (int j = 0; j < 10; j++) begin
      tick();
      ep = (j == 6) ? 3'b101 : 3'b000;
      el = (j >= 6) ? 3'b101 : 3'b000;
      check_outs("t6 after reset", j, ep, el);
    end
    drain("t6");
    $display("case 6 reset mid-press: %0d/%0d so far", n_pass, n_checks);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
